alu_rr_scheduler: RTL

//  Shares one instance of the team's combinational 8-bit ALU core (module ALU) between NREQ requesters.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/ALU.sv | 45 ++++
 rtl/alu_rr_scheduler_rr_arbiter.sv | 31 +++
 rtl/alu_rr_scheduler.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU core and the round-robin scheduler that feeds it:
// ALU opcodes, response flag bit positions and scheduler FSM states.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD     = 3'b000,
      ALU_SUB     = 3'b001,
      ALU_AND     = 3'b010,
      ALU_OR      = 3'b011,
      ALU_ADD_SHL = 3'b100,
      ALU_SUB_SHL = 3'b101,
      ALU_ADD_SHR = 3'b110,
      ALU_SUB_SHR = 3'b111
   } alu_op_t;

   localparam int FLG_C = 0;
   localparam int FLG_Z = 1;
   localparam int FLG_N = 2;
   localparam int FLG_V = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } sched_state_t;

endpackage

// File: rtl/ALU.sv
// Combinational 8-bit ALU core: one adder shared by add/sub and the shift ops,
// plus bitwise AND/OR. Shifts act on the adder sum.
module ALU
   import alu_pkg::*;
(
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [2:0] ALU_control,
   input  logic [3:0] samt,
   output logic [7:0] RESULT,
   output logic       OVERFLOW,
   output logic       NEGATIVE,
   output logic       ZERO,
   output logic       CARRY
);

   logic       w_sub;
   logic       w_is_and;
   logic [7:0] w_b_eff;
   logic [8:0] w_sum;

   assign w_sub    = (ALU_control == ALU_SUB) || (ALU_control == ALU_SUB_SHL) ||
                     (ALU_control == ALU_SUB_SHR);
   assign w_is_and = (ALU_control == ALU_AND);
   assign w_b_eff  = w_sub ? ~B : B;
   assign w_sum    = {1'b0, A} + {1'b0, w_b_eff} + {8'b0, w_sub};

   always_comb begin
      RESULT = w_sum[7:0];
      case (ALU_control)
         ALU_AND:                  RESULT = A & B;
         ALU_OR:                   RESULT = A | B;
         ALU_ADD_SHL, ALU_SUB_SHL: RESULT = w_sum[7:0] << samt;
         ALU_ADD_SHR, ALU_SUB_SHR: RESULT = w_sum[7:0] >> samt;
         default:                  RESULT = w_sum[7:0];
      endcase
   end

   // Carry/overflow always come from the adder, except AND which forces them low.
   assign CARRY    = w_is_and ? 1'b0 : w_sum[8];
   assign OVERFLOW = w_is_and ? 1'b0 : ((A[7] == w_b_eff[7]) && (w_sum[7] != A[7]));
   assign ZERO     = (RESULT == 8'h00);
   assign NEGATIVE = RESULT[7];

endmodule

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: scans requests upward from the pointer,
// wrapping, and returns the first hit as one-hot grant plus encoded index.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_idx
);

   always_comb begin
      logic found;
      int   idx;
      found   = 1'b0;
      idx     = 0;
      o_grant = '0;
      o_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(i_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && i_req[idx]) begin
            found        = 1'b1;
            o_grant[idx] = 1'b1;
            o_idx        = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU core between NREQ requesters: round-robin grant, registered
// operands, one registered response per op held until the consumer takes it.
module alu_rr_scheduler
   import alu_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int CNTW = 16,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NREQ-1:0]   i_req_valid,
   output logic [NREQ-1:0]   o_req_ready,
   input  logic [NREQ*8-1:0] i_req_a,
   input  logic [NREQ*8-1:0] i_req_b,
   input  logic [NREQ*3-1:0] i_req_op,
   input  logic [NREQ*4-1:0] i_req_samt,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [IDW-1:0]    o_rsp_id,
   output logic [7:0]        o_rsp_result,
   output logic [3:0]        o_rsp_flags,
   output logic              o_busy,
   output logic [CNTW-1:0]   o_ops_done
);

   sched_state_t    r_state;
   sched_state_t    w_next_state;
   logic [IDW-1:0]  r_ptr;
   logic [7:0]      r_a;
   logic [7:0]      r_b;
   logic [2:0]      r_op;
   logic [3:0]      r_samt;
   logic [IDW-1:0]  r_id;
   logic [IDW-1:0]  r_rsp_id;
   logic [7:0]      r_rsp_result;
   logic [3:0]      r_rsp_flags;
   logic [CNTW-1:0] r_ops_done;

   logic [NREQ-1:0] w_grant;
   logic [IDW-1:0]  w_gidx;
   logic            w_any_req;
   logic            w_take;
   logic            w_rsp_done;
   logic [7:0]      w_result;
   logic            w_ovf;
   logic            w_neg;
   logic            w_zero;
   logic            w_carry;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_req   (i_req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_gidx)
   );

   ALU u_alu (
      .A           (r_a),
      .B           (r_b),
      .ALU_control (r_op),
      .samt        (r_samt),
      .RESULT      (w_result),
      .OVERFLOW    (w_ovf),
      .NEGATIVE    (w_neg),
      .ZERO        (w_zero),
      .CARRY       (w_carry)
   );

   assign w_any_req  = |i_req_valid;
   assign w_take     = (r_state == ST_IDLE) && w_any_req;
   assign w_rsp_done = (r_state == ST_RESP) && i_rsp_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_any_req)   w_next_state = ST_EXEC;
         ST_EXEC:                  w_next_state = ST_RESP;
         ST_RESP: if (i_rsp_ready) w_next_state = ST_IDLE;
         default:                  w_next_state = ST_IDLE;
      endcase
   end

   // Grant is suppressed while reset is held so no handshake is reported that cannot land.
   always_comb begin
      o_req_ready = '0;
      o_rsp_valid = 1'b0;
      o_busy      = 1'b0;
      if (r_state == ST_IDLE && !i_rst) o_req_ready = w_grant;
      if (r_state == ST_RESP)           o_rsp_valid = 1'b1;
      if (r_state != ST_IDLE)           o_busy      = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_op   <= '0;
         r_samt <= '0;
         r_id   <= '0;
      end else if (w_take) begin
         r_a    <= i_req_a[8*w_gidx +: 8];
         r_b    <= i_req_b[8*w_gidx +: 8];
         r_op   <= i_req_op[3*w_gidx +: 3];
         r_samt <= i_req_samt[4*w_gidx +: 4];
         r_id   <= w_gidx;
         r_ptr  <= (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rsp_id     <= '0;
         r_rsp_result <= '0;
         r_rsp_flags  <= '0;
         r_ops_done   <= '0;
      end else begin
         if (r_state == ST_EXEC) begin
            r_rsp_id            <= r_id;
            r_rsp_result        <= w_result;
            r_rsp_flags[FLG_C]  <= w_carry;
            r_rsp_flags[FLG_Z]  <= w_zero;
            r_rsp_flags[FLG_N]  <= w_neg;
            r_rsp_flags[FLG_V]  <= w_ovf;
         end
         if (w_rsp_done) r_ops_done <= r_ops_done + 1'b1;
      end
   end

   assign o_rsp_id     = r_rsp_id;
   assign o_rsp_result = r_rsp_result;
   assign o_rsp_flags  = r_rsp_flags;
   assign o_ops_done   = r_ops_done;

endmodule
